// File: rtl/salsa_pkg.sv
// Shared types and constants for the Salsa20 stream controller and its keystream buffer.
package salsa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int BLOCK_BYTES = 64;
  localparam int LOAD_WORDS  = 12;
  localparam int IDX_W       = $clog2(BLOCK_BYTES);

  localparam logic [3:0] CFG_KEY_LAST = 4'd7;
  localparam logic [3:0] CFG_NONCE0   = 4'd8;
  localparam logic [3:0] CFG_NONCE1   = 4'd9;
  localparam logic [3:0] CFG_CTR_LO   = 4'd10;
  localparam logic [3:0] CFG_CTR_HI   = 4'd11;

endpackage

// File: rtl/salsa_ks_buf.sv
// 64x8 keystream block buffer: one write port fed by the core, one combinational read port
// for the drain side; clr rewinds both indices so no partial block survives a block change.
module salsa_ks_buf
  import salsa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_adv,
  output logic [7:0]       rd_data,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx
);

  logic [7:0] mem [0:BLOCK_BYTES-1];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) wr_idx <= wr_idx + 1'b1;
      if (rd_adv) rd_idx <= rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/salsa_stream_ctrl.sv
// Salsa20 block controller: loads key/nonce/counter into the core, buffers its 64-byte output
// and drains it one byte per msg/out handshake. Define SALSA_XOR_EN to XOR msg_data into out_data.
module salsa_stream_ctrl
  import salsa_pkg::*;
#(
  parameter logic [63:0] CTR_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  output logic        msg_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        hash_start,
  output logic [31:0] hash_data_in,
  input  logic        hash_ready,
  input  logic        hash_writes,
  input  logic [7:0]  hash_data_out,
  output logic        busy
);

  state_t            state, state_nxt;
  logic [31:0]       key [0:7];
  logic [31:0]       nonce [0:1];
  logic [63:0]       ctr;
  logic [3:0]        load_cnt;
  logic [31:0]       load_word;
  logic              buf_clr, buf_wr, rd_adv, ctr_inc;
  logic [7:0]        buf_byte;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  salsa_ks_buf u_ks_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (hash_data_out),
    .rd_adv  (rd_adv),
    .rd_data (buf_byte),
    .wr_idx  (wr_idx),
    .rd_idx  (rd_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      load_cnt <= '0;
    end else begin
      state    <= state_nxt;
      load_cnt <= (state == LOAD) ? load_cnt + 4'd1 : 4'd0;
    end
  end

  // Configuration is frozen while a block is in flight so a block always uses one key set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) key[i] <= '0;
      nonce[0] <= '0;
      nonce[1] <= '0;
      ctr      <= CTR_INIT;
    end else if (state == IDLE && cfg_we) begin
      if (cfg_addr <= CFG_KEY_LAST) key[cfg_addr[2:0]] <= cfg_data;
      else if (cfg_addr == CFG_NONCE0 || cfg_addr == CFG_NONCE1) nonce[cfg_addr[0]] <= cfg_data;
      else if (cfg_addr == CFG_CTR_LO) ctr[31:0] <= cfg_data;
      else if (cfg_addr == CFG_CTR_HI) ctr[63:32] <= cfg_data;
    end else if (ctr_inc) begin
      ctr <= ctr + 64'd1;
    end
  end

  // key[0] goes out with hash_start; load_cnt then walks the remaining eleven words.
  always_comb begin
    load_word = 32'h0;
    case (load_cnt)
      4'd7:    load_word = nonce[0];
      4'd8:    load_word = nonce[1];
      4'd9:    load_word = ctr[31:0];
      4'd10:   load_word = ctr[63:32];
      default: if (load_cnt < 4'd7) load_word = key[load_cnt[2:0] + 3'd1];
    endcase
  end

  always_comb begin
    state_nxt    = state;
    hash_start   = 1'b0;
    hash_data_in = 32'h0;
    msg_ready    = 1'b0;
    out_valid    = 1'b0;
    buf_clr      = 1'b0;
    buf_wr       = 1'b0;
    rd_adv       = 1'b0;
    ctr_inc      = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (msg_valid && hash_ready) begin
            hash_start   = 1'b1;
            hash_data_in = key[0];
            buf_clr      = 1'b1;
            state_nxt    = LOAD;
          end
        end
        LOAD: begin
          hash_data_in = load_word;
          if (load_cnt == 4'(LOAD_WORDS - 2)) state_nxt = WAIT;
        end
        WAIT: begin
          if (hash_writes) begin
            buf_wr    = 1'b1;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (hash_writes) begin
            buf_wr = 1'b1;
            if (wr_idx == IDX_W'(BLOCK_BYTES - 1)) begin
              ctr_inc   = 1'b1;
              state_nxt = DRAIN;
            end
          end
        end
        DRAIN: begin
          out_valid = msg_valid;
          msg_ready = out_ready;
          if (msg_valid && out_ready) begin
            rd_adv = 1'b1;
            if (rd_idx == IDX_W'(BLOCK_BYTES - 1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef SALSA_XOR_EN
  assign out_data = msg_data ^ buf_byte;
`else
  logic unused_msg_data;
  assign unused_msg_data = ^msg_data;
  assign out_data = buf_byte;
`endif

endmodule

// File: tb/tb_salsa_stream_ctrl.sv
// Randomized bench for salsa_stream_ctrl with an inline core model and a word/byte-level reference.
module tb_salsa_stream_ctrl;

  localparam logic [63:0] TB_CTR_INIT = 64'h0123_4567_89AB_CDEF;
`ifdef SALSA_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        msg_valid;
  logic [7:0]  msg_data;
  logic        msg_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        hash_start;
  logic [31:0] hash_data_in;
  logic        hash_ready;
  logic        hash_writes;
  logic [7:0]  hash_data_out;
  logic        busy;

  salsa_stream_ctrl #(.CTR_INIT(TB_CTR_INIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .msg_valid     (msg_valid),
    .msg_data      (msg_data),
    .msg_ready     (msg_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .hash_start    (hash_start),
    .hash_data_in  (hash_data_in),
    .hash_ready    (hash_ready),
    .hash_writes   (hash_writes),
    .hash_data_out (hash_data_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference state: what the controller should currently hold
  logic [31:0] m_key [8];
  logic [31:0] m_nonce [2];
  logic [63:0] m_ctr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    if (i < 8) return m_key[i];
    if (i < 10) return m_nonce[i - 8];
    if (i == 10) return m_ctr[31:0];
    return m_ctr[63:32];
  endfunction

  function automatic logic [7:0] exp_out(input logic [7:0] b, input logic [7:0] md);
    return b ^ (XOR_EN ? md : 8'h00);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_key[i] = 32'h0;
    m_nonce[0] = 32'h0;
    m_nonce[1] = 32'h0;
    m_ctr = TB_CTR_INIT;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    next_cycle();
    cfg_we = 1'b0;
    if (addr < 4'd8) m_key[addr[2:0]] = data;
    else if (addr < 4'd10) m_nonce[addr[0]] = data;
    else if (addr == 4'd10) m_ctr[31:0] = data;
    else if (addr == 4'd11) m_ctr[63:32] = data;
  endtask

  // mode 0: bytes 00..3F, msg_data FF, out_ready toggling, cfg write during drain.
  // mode 1: random bytes, gaps and handshakes. abort_at >= 0 resets on that capture byte.
  task automatic run_block(input int mode, input int abort_at);
    logic [7:0] kb [64];
    int idx, n, guard;
    bit stalled;
    for (int i = 0; i < 64; i++) kb[i] = (mode == 0) ? 8'(i) : 8'($urandom);

    msg_valid = 1'b1; hash_ready = 1'b1; msg_data = 8'h00;
    #1;
    check_val("start_pulse", 64'(hash_start), 64'd1);
    check_val("load_w0", 64'(hash_data_in), 64'(exp_word(0)));
    next_cycle();
    hash_ready = 1'b0;
    for (int i = 1; i < 12; i++) begin
      msg_valid = 1'($urandom);
      #1;
      check_val("start_once", 64'(hash_start), 64'd0);
      check_val("load_w", 64'(hash_data_in), 64'(exp_word(i)));
      check_val("load_busy", 64'(busy), 64'd1);
      next_cycle();
    end

    for (int g = $urandom_range(0, 3); g > 0; g--) begin
      hash_writes = 1'b0;
      #1;
      check_val("wait_data_zero", 64'(hash_data_in), 64'd0);
      check_val("wait_msg_ready", 64'(msg_ready), 64'd0);
      next_cycle();
    end

    idx = 0;
    guard = 0;
    while (idx < 64 && guard < 1000) begin
      guard++;
      msg_valid = 1'($urandom);
      if (mode != 0 && $urandom_range(0, 3) == 0) begin
        hash_writes = 1'b0;
      end else begin
        hash_writes = 1'b1;
        hash_data_out = kb[idx];
        if (idx == abort_at) reset = 1'b1;
      end
      #1;
      check_val("cap_out_valid", 64'(out_valid), 64'd0);
      check_val("cap_data_zero", 64'(hash_data_in), 64'd0);
      next_cycle();
      if (reset) begin
        reset = 1'b0; hash_writes = 1'b0; msg_valid = 1'b0;
        model_reset();
        #1;
        check_val("abort_idle", 64'(busy), 64'd0);
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_msg_ready", 64'(msg_ready), 64'd0);
        return;
      end
      if (hash_writes) idx++;
    end
    hash_writes = 1'b0;
    if (idx < 64) check_val("capture_timeout", 64'(idx), 64'd64);
    m_ctr = m_ctr + 64'd1;

    n = 0; guard = 0; stalled = 1'b0;
    while (n < 64 && guard < 2000) begin
      if (!stalled) begin
        msg_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        msg_data  = (mode == 0) ? 8'hFF : 8'($urandom);
      end
      out_ready = (mode == 0) ? (guard % 2 == 0) : 1'($urandom);
      cfg_we = (mode == 0 && guard == 5);
      cfg_addr = 4'd0; cfg_data = 32'hDEADBEEF;
      #1;
      check_val("drain_out_valid", 64'(out_valid), 64'(msg_valid));
      check_val("drain_msg_ready", 64'(msg_ready), 64'(out_ready));
      if (msg_valid)
        check_val(stalled ? "drain_stall_data" : "drain_data",
                  64'(out_data), 64'(exp_out(kb[n], msg_data)));
      stalled = msg_valid && !out_ready;
      if (msg_valid && out_ready) n++;
      next_cycle();
      guard++;
    end
    cfg_we = 1'b0; msg_valid = 1'b0; out_ready = 1'b0;
    if (n < 64) check_val("drain_timeout", 64'(n), 64'd64);
    #1;
    check_val("end_idle", 64'(busy), 64'd0);
    check_val("end_out_valid", 64'(out_valid), 64'd0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 32'h0;
    msg_valid = 1'b0; msg_data = 8'h00; out_ready = 1'b0;
    hash_ready = 1'b0; hash_writes = 1'b0; hash_data_out = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    msg_valid = 1'b1; hash_ready = 1'b1; out_ready = 1'b1;
    #1;
    check_val("rst_hash_start", 64'(hash_start), 64'd0);
    check_val("rst_data_in", 64'(hash_data_in), 64'd0);
    check_val("rst_msg_ready", 64'(msg_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0; msg_valid = 1'b1; hash_ready = 1'b0; out_ready = 1'b0;
    next_cycle();

    // Idle must not start without both msg_valid and hash_ready
    for (int i = 0; i < 2; i++) begin
      msg_valid = (i == 0); hash_ready = (i != 0);
      #1;
      check_val("idle_no_start", 64'(hash_start), 64'd0);
      next_cycle();
      check_val("idle_stays", 64'(busy), 64'd0);
    end
    msg_valid = 1'b0; hash_ready = 1'b0;

    for (int i = 0; i < 8; i++) cfg_write(4'(i), 32'h03020100 + 32'h04040404 * i);
    cfg_write(4'd8, 32'd1);
    cfg_write(4'd9, 32'd2);
    cfg_write(4'd10, 32'd5);
    cfg_write(4'd11, 32'd0);
    run_block(0, -1);
    run_block(1, -1);

    cfg_write(4'd10, 32'hFFFF_FFFF);
    cfg_write(4'd11, 32'hFFFF_FFFF);
    run_block(1, -1);
    run_block(1, 29);
    run_block(1, -1);
    run_block(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/salsa_stream_ctrl.md
SALSA_STREAM_CTRL -- requirements
Module: salsa_stream_ctrl

Interface
REQ-001 SHALL have parameter: CTR_INIT, 64'h0, block-counter value applied at reset.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have ports: cfg_we in 1; cfg_addr in 4; cfg_data in 32, config write (0-7 key[0..7], 8-9 nonce[0..1], 10-11 counter low/high word).
REQ-004 SHALL have ports: msg_valid in 1; msg_data in 8; msg_ready out 1, message byte input handshake.
REQ-005 SHALL have ports: out_valid out 1; out_data out 8; out_ready in 1, result byte output handshake.
REQ-006 SHALL have ports: hash_start out 1; hash_data_in out 32; hash_ready in 1; hash_writes in 1; hash_data_out in 8, salsa core driver interface.
REQ-007 SHALL have port: busy out 1, high in every state except IDLE.

Function
REQ-008 SHALL use FSM states IDLE, LOAD, WAIT, CAPTURE, DRAIN.
REQ-009 IDLE->LOAD when msg_valid=1 and hash_ready=1; hash_start=1 and hash_data_in=key[0] in that cycle only.
REQ-010 LOAD SHALL drive exactly one word per cycle for 11 cycles in order key[1..7], nonce[0], nonce[1], ctr[31:0], ctr[63:32], then enter WAIT.
REQ-011 WAIT SHALL hold until hash_writes=1, then enter CAPTURE without losing that cycle's byte.
REQ-012 CAPTURE SHALL store hash_data_out into 64x8 buffer index 0..63 on each hash_writes=1 cycle; after index 63, increment block counter by 1 (2^64-1 wraps to 0) and enter DRAIN.
REQ-013 DRAIN SHALL emit buffer bytes 0..63 in order, one per out_valid&out_ready transfer; msg_ready=out_ready in DRAIN, 0 elsewhere.
REQ-014 out_valid SHALL equal msg_valid in DRAIN; out_data combinational from msg_data and buffer[rd_idx].
REQ-015 out_valid/out_data SHALL hold stable while out_ready=0.
REQ-016 After byte 63 transfers, SHALL return to IDLE; next block requested only when a new msg_valid arrives.
REQ-017 cfg_we SHALL update registers only in IDLE; writes in other states SHALL be ignored.
REQ-018 hash_data_in SHALL be 32'h0 outside the 12 load cycles.
REQ-019 Unused buffer bytes SHALL be discarded on block change; no partial-block carry-over.

Reset
REQ-020 On reset: state=IDLE, key/nonce=0, counter=CTR_INIT, rd/wr index=0, hash_start=0, hash_data_in=0, msg_ready=0, out_valid=0, busy=0.
REQ-021 Reset mid-LOAD/WAIT/CAPTURE/DRAIN SHALL abort immediately, discarding buffer; the core is reset by the same reset net.
REQ-022 reset SHALL take priority over cfg_we and all handshakes in the same cycle.

Configuration
REQ-023 Macro SALSA_XOR_EN defined: out_data = msg_data XOR buffer byte (encrypt/decrypt).
REQ-024 SALSA_XOR_EN undefined: out_data = raw buffer byte; msg_data ignored, msg_valid acts as byte request only.

Structure
REQ-025 Shared package salsa_pkg SHALL hold state enum, BLOCK_BYTES=64, LOAD_WORDS=12, cfg address constants.
REQ-026 One sub-module salsa_ks_buf (64x8 register buffer, write port + read port, index counters).
REQ-027 Top SHALL instantiate salsa_ks_buf; core instantiation remains at system level.

Verification
REQ-028 cfg key=32'h03020100+32'h04040404*i, nonce={1,2}, ctr=5; msg_valid=1 -> hash_data_in sequence key0..key7,1,2,5,0 on 12 consecutive cycles, hash_start only first.
REQ-029 Core model writes bytes 8'h00..8'h3F, msg_data=8'hFF, SALSA_XOR_EN -> out_data 8'hFF..8'hC0, 64 transfers, then counter=6.
REQ-030 out_ready toggled 1/0 each cycle during DRAIN -> no byte duplicated or skipped, out_data stable while stalled.
REQ-031 ctr=64'hFFFF_FFFF_FFFF_FFFF, one block -> next LOAD sends ctr words 0,0.
REQ-032 reset asserted on 30th CAPTURE byte -> next cycle IDLE, out_valid=0, counter=CTR_INIT; fresh block restarts at index 0.
REQ-033 cfg_we addr 0 data 32'hDEADBEEF during DRAIN -> next LOAD still sends old key[0].
